// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NRD      = 2;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_BYPASS   = 1;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_SWEEP = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_e;

    // Byte lane select used identically by the array write and the read bypass.
    function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       be);
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks a pointer over every entry, one per cycle, then
// spends one DONE cycle before returning to IDLE.
module rf_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ClrReq,
    output logic              Busy,
    output logic              ClrDone,
    output logic              clr_stb_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLR_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            CLR_IDLE: begin
                if (ClrReq) begin
                    state_d = CLR_SWEEP;
                    ptr_d   = '0;
                end
            end
            CLR_SWEEP: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == {ADDR_W{1'b1}}) state_d = CLR_DONE;
            end
            CLR_DONE: state_d = CLR_IDLE;
            default:  state_d = CLR_IDLE;
        endcase
    end

    assign Busy       = (state_q != CLR_IDLE);
    assign ClrDone    = (state_q == CLR_DONE);
    assign clr_stb_o  = (state_q == CLR_SWEEP);
    assign clr_addr_o = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: one byte-enabled write port, NRD registered read
// ports with optional same-edge write forwarding, and a hardware clear sweep.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NRD      = DEF_NRD,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = DEF_BYPASS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWr,
    input  logic [ADDR_W-1:0]     WrReg,
    input  logic [DATA_W-1:0]     WrData,
    input  logic [DATA_W/8-1:0]   WrBe,
    input  logic [NRD-1:0]        RdEn,
    input  logic [NRD*ADDR_W-1:0] RdReg,
    output logic [NRD*DATA_W-1:0] RdData,
    output logic [NRD-1:0]        RdValid,
    input  logic                  ClrReq,
    output logic                  Busy,
    output logic                  ClrDone
);

    localparam int NREGS  = 2 ** ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] regs [NREGS];
    logic              clr_stb;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_acc;
    logic [DATA_W-1:0] wr_merged;

    rf_clear_seq #(.ADDR_W(ADDR_W)) u_clr (
        .clk        (clk),
        .reset      (reset),
        .ClrReq     (ClrReq),
        .Busy       (Busy),
        .ClrDone    (ClrDone),
        .clr_stb_o  (clr_stb),
        .clr_addr_o (clr_addr)
    );

    // Writes to the hardwired-zero entry are rejected here so that neither the
    // array nor the bypass path ever sees them.
    assign wr_acc = RegWr && !Busy && (|WrBe) && !((ZERO_REG != 0) && (WrReg == '0));

    always_comb begin
        wr_merged = regs[WrReg];
        for (int b = 0; b < NBYTES; b++) begin
            wr_merged[8*b +: 8] = byte_merge(regs[WrReg][8*b +: 8], WrData[8*b +: 8], WrBe[b]);
        end
    end

    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        logic [DATA_W-1:0] q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                q <= '0;
            end else if (clr_stb && (clr_addr == ADDR_W'(r))) begin
                q <= '0;
            end else if (wr_acc && (WrReg == ADDR_W'(r))) begin
                q <= wr_merged;
            end
        end

        assign regs[r] = q;
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] data_d, data_q;
        logic              vld_q;

        assign ra = RdReg[p*ADDR_W +: ADDR_W];

        always_comb begin
            data_d = regs[ra];
            if ((BYPASS != 0) && wr_acc && (WrReg == ra)) data_d = wr_merged;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                data_q <= '0;
                vld_q  <= 1'b0;
            end else begin
                vld_q <= RdEn[p];
                if (RdEn[p]) data_q <= data_d;
            end
        end

        assign RdData[p*DATA_W +: DATA_W] = data_q;
        assign RdValid[p]                 = vld_q;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file: one byte-enabled write port, `NRD` registered read ports with optional write-to-read bypass, an optional hardwired-zero register 0, and a hardware clear sequencer that zeroes the array one entry per cycle on request. It replaces the fixed 32×32, two-read-port register file in the datapath. It serves as the CPU architectural register file and as scratch storage for wider or narrower datapaths.

## Interface
Parameters:
- `DATA_W`, 32: register width in bits; multiple of 8.
- `ADDR_W`, 5: address width; `NREGS = 2**ADDR_W`.
- `NRD`, 2: number of read ports, 1..4.
- `ZERO_REG`, 1: when 1, register 0 reads as 0 and ignores writes.
- `BYPASS`, 1: when 1, a same-cycle write is forwarded to a matching read.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low; asserted at 0.
- `RegWr` in 1: write strobe.
- `WrReg` in `ADDR_W`: write address.
- `WrData` in `DATA_W`: write data.
- `WrBe` in `DATA_W/8`: byte enables; bit b gates `WrData[8b+7:8b]`.
- `RdEn` in `NRD`: per-port read request.
- `RdReg` in `NRD*ADDR_W`: packed read addresses; port i at `[i*ADDR_W +: ADDR_W]`.
- `RdData` out `NRD*DATA_W`: packed registered read data.
- `RdValid` out `NRD`: port i data valid this cycle.
- `ClrReq` in 1: start clear sweep; single-cycle pulse or level.
- `Busy` out 1: sweep in progress; writes are dropped.
- `ClrDone` out 1: one-cycle pulse at sweep end.

## Operation
- Reset (`reset`=0): all registers 0; `RdData`=0, `RdValid`=0, `Busy`=0, `ClrDone`=0; FSM to IDLE. Takes effect immediately, including mid-sweep; the sweep is not resumed.
- Write: at an edge with `RegWr`=1 and `Busy`=0, each byte of `reg[WrReg]` whose `WrBe` bit is set takes the corresponding `WrData` byte. Other bytes are held. `WrBe`=0 is a no-op. With `ZERO_REG`=1, a write to address 0 is discarded.
- Read: at an edge with `RdEn[i]`=1, `RdData[i]` loads the contents of `reg[RdReg[i]]` and `RdValid[i]`=1 for the following cycle. With `RdEn[i]`=0, `RdData[i]` holds its last value and `RdValid[i]`=0. All ports are independent; any ports may read the same address.
- Bypass (`BYPASS`=1): if a read at an edge matches an accepted write at the same edge, the read returns the byte-merged new value. With `BYPASS`=0 it returns the pre-write value. A write dropped while Busy is never forwarded.
- Register 0 with `ZERO_REG`=1 always reads 0, including under bypass.
- Clear FSM states:
  - IDLE: `ClrReq`=1 → SWEEP, `ptr`=0.
  - SWEEP: each edge zeroes `reg[ptr]` and increments `ptr`; after clearing `ptr`=`NREGS-1` → DONE.
  - DONE: `ClrDone`=1 for one cycle, then → IDLE.
  - `Busy`=1 in SWEEP and DONE.
  - `ClrReq` is ignored outside IDLE.
- Reads during Busy are served normally and return current contents: already-cleared entries read 0, pending entries read their old value.
- `ClrReq` and `RegWr` at the same edge in IDLE: the write is accepted, and the sweep later clears it.

## Timing
- Read latency is 1 cycle, address to `RdData`/`RdValid`; full throughput on every port every cycle.
- Write is visible to reads issued at the next edge, or at the same edge with `BYPASS`=1.
- `ClrReq` sampled at edge k:
  - `Busy`=1 after edge k.
  - `reg[j]` is zeroed at edge k+1+j.
  - `ClrDone`=1 and `Busy`=1 during the cycle after edge k+NREGS.
  - `Busy`=0 after edge k+NREGS+1.
- Total sweep is `NREGS`+1 busy cycles.
- No combinational path from any input to any output.

## Structure
- Package `regfile_pkg`: clear-FSM state enum (IDLE, SWEEP, DONE), default parameter constants, and a byte-merge function (old, new, be) shared by the write path and the bypass path.
- Sub-module `rf_clear_seq`: the clear FSM plus the `ADDR_W`-bit pointer. Outputs `Busy`, `ClrDone`, the clear strobe and the clear address.
- Array, write logic and read ports live in the top level; read ports are generated by loop over `NRD`.

## Test plan
- Reset then read: after `reset` deasserts, read all 32 addresses on both ports → every `RdData`=0, `RdValid`=1 one cycle after each `RdEn`.
- Byte-enable write: write `0xAABBCCDD` to r5 with `WrBe`=1111, then `0x11223344` with `WrBe`=0101 → read r5 = `0xAA22CC44`.
- Bypass: same edge write `0xDEADBEEF` to r7 and read r7 on port 0 → `RdData`=`0xDEADBEEF` with `BYPASS`=1, old value with `BYPASS`=0. Write to r0 with `ZERO_REG`=1 → reads 0.
- Clear sweep: fill r1..r31 with nonzero values, pulse `ClrReq` → `Busy` high for 33 cycles, `ClrDone` pulse on the last. A write to r3 during Busy is dropped. Afterward all registers read 0.
- Reset mid-sweep: assert `reset` 10 cycles into a sweep → `Busy`=0 and all outputs 0 immediately. A fresh `ClrReq` then runs a full 33-cycle sweep.
- Parameter variant: `DATA_W`=16, `ADDR_W`=3, `NRD`=4. Four ports read distinct addresses in the same cycle → each returns its own register value one cycle later.
